// File: rtl/fetch_queue_stage_pkg.sv
// Shared fetch-side types and constants, also imported by the decode stage.
package fetch_queue_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013; // addi x0,x0,0

    // One buffered fetch result: the word and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous prefetch FIFO with clear; head is read straight from storage.
module fetch_fifo
    import fetch_queue_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  fetch_entry_t             data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; needs no reset because empty entries are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    // The parent's issue gate must never let a response land in a full queue.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !clear_i));

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch front end: owns the PC, issues in-order imem requests, buffers
// responses in a prefetch queue and drops in-flight responses on redirect.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        InstrValidF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF_out,
    output logic [31:0] PCPlus4F
);

    localparam int unsigned CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

    logic          run_q;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [31:0]   last_pc_q;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic [31:0]   target;
    logic          full, empty, push, pop, issue;
    fetch_entry_t  head, wr_entry;

    assign target    = word_align(PCTargetE);
    assign inflight  = {1'b0, count} + {1'b0, outstanding_q};
    assign imem_req  = run_q && (inflight < DEPTH_W) && !PCSrcE && (drop_q == '0);
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;
    assign push      = imem_rvalid && (drop_q == '0) && !PCSrcE;
    assign pop       = !empty && !StallD && !PCSrcE;
    assign wr_entry  = '{pc: rsp_pc_q, instr: imem_rdata};

    fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clear_i (PCSrcE),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign InstrValidF = !empty;
    assign InstrF      = empty ? NOP_INSTR : head.instr;
    assign PCF_out     = empty ? last_pc_q : head.pc;
    assign PCPlus4F    = PCF_out + 32'd4;

    // Next-state for PC, response PC, outstanding count and drop count.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q;
        unique case ({issue, imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (PCSrcE) begin
            pc_d     = target;
            rsp_pc_d = target;
            // Any drops still pending are already part of outstanding, so
            // everything in flight minus this cycle's response is discarded once.
            drop_d   = outstanding_q - CW'(imem_rvalid);
        end else begin
            if (issue) pc_d = pc_q + 32'd4;
            if (imem_rvalid) begin
                if (drop_q != '0) drop_d   = drop_q - CW'(1);
                else              rsp_pc_d = rsp_pc_q + 32'd4;
            end
        end
    end

    // State registers; run_q keeps requests off until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            last_pc_q     <= '0;
        end else begin
            run_q         <= 1'b1;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (!empty) last_pc_q <= head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage with an addr-as-data memory model.
module tb_fetch_queue_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        StallD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        InstrValidF;
    logic [31:0] InstrF, PCF_out, PCPlus4F;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        exp_q[$];
    mreq_t       memq[$];
    logic [31:0] grant_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          vectors = 0;
    int          miscompares = 0;
    int          pops = 0;

    fetch_queue_stage #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH),
        .NOP_INSTR   (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .StallD      (StallD),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .InstrValidF (InstrValidF),
        .InstrF      (InstrF),
        .PCF_out     (PCF_out),
        .PCPlus4F    (PCPlus4F)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] glog(input int i);
        return (grant_log.size() > i) ? grant_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic load_exp(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back('{pc: p, instr: p});
            p = p + 32'd4;
        end
    endtask

    // In-order memory: grants sampled mid-cycle, response presented lat cycles later.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst && imem_req && imem_gnt) begin
                memq.push_back('{addr: imem_addr, due: cyc + lat});
                grant_log.push_back(imem_addr);
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                memq.delete();
                imem_rvalid = 1'b0;
            end else if (memq.size() > 0 && memq[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memq[0].addr;
                void'(memq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: every accepted pop is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && InstrValidF && !StallD && !PCSrcE) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_unexpected: got PC %h, no entry expected", PCF_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_instr", InstrF, e.instr);
                    check("pop_pc", PCF_out, e.pc);
                    check("pop_pc4", PCPlus4F, e.pc + 32'd4);
                end
                pops++;
            end
        end
    end

    task automatic pulse_reset(input int l);
        @(posedge clk);
        #2 rst = 1'b0;
        lat = l;
        StallD = 1'b0;
        PCSrcE = 1'b0;
        load_exp(RST_PC);
        grant_log.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_pops(input string name, input int n, input int budget);
        int target;
        int k;
        target = pops + n;
        k = 0;
        while (pops < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check1(name, pops >= target, 1'b1);
    endtask

    // Redirect for one cycle; the scoreboard is reloaded from the aligned target.
    task automatic redirect(input logic [31:0] tgt, input logic [31:0] aligned);
        PCSrcE    = 1'b1;
        PCTargetE = tgt;
        load_exp(aligned);
        grant_log.delete();
        @(negedge clk);
        check1("redirect_req_off", imem_req, 1'b0);
        @(posedge clk);
        #2 PCSrcE = 1'b0;
        @(negedge clk);
        check1("redirect_flushed", InstrValidF, 1'b0);
        check("redirect_nop", InstrF, 32'h0000_0013);
    endtask

    initial begin
        int fg, fv, k;
        logic ok;
        imem_gnt  = 1'b1;
        StallD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        load_exp(RST_PC);

        // Reset values
        repeat (2) @(negedge clk);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", InstrValidF, 1'b0);
        check("rst_instr", InstrF, 32'h0000_0013);
        check("rst_pcf", PCF_out, 32'h0);
        check("rst_pc4", PCPlus4F, 32'h4);

        // 1-cycle memory, free running, wrapping PC sequence
        @(posedge clk);
        #2 rst = 1'b1;
        fg = -1;
        fv = -1;
        k  = 0;
        while ((fg < 0 || fv < 0) && k < 20) begin
            @(negedge clk);
            if (fg < 0 && imem_req && imem_gnt) fg = cyc;
            if (fv < 0 && InstrValidF) fv = cyc;
            k++;
        end
        check("first_valid_latency", 32'(fv - fg), 32'd2);
        wait_pops("t1_pops", 10, 40);
        check("t1_addr0", glog(0), 32'hFFFF_FFF8);
        check("t1_addr1", glog(1), 32'hFFFF_FFFC);
        check("t1_addr2", glog(2), 32'h0000_0000);

        // Decode stall: head holds, requests stop once the queue is full
        @(posedge clk);
        #2 StallD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("stall_valid", InstrValidF, 1'b1);
            check("stall_head_pc", PCF_out, (exp_q.size() > 0) ? exp_q[0].pc : 32'hDEAD_BEEF);
        end
        check1("stall_req_off", imem_req, 1'b0);
        @(posedge clk);
        #2 StallD = 1'b0;
        wait_pops("t2_pops", 8, 30);

        // Latency 3, redirect with two responses in flight
        pulse_reset(3);
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            ok = !imem_rvalid && memq.size() == 2;
            if (ok || k >= 30) break;
            k++;
        end
        check1("t3_sync", ok, 1'b1);
        redirect(32'h0000_0100, 32'h0000_0100);
        wait_pops("t3_pops", 6, 60);
        check("t3_first_addr", glog(0), 32'h0000_0100);

        // Latency 2, redirect coinciding with a response and a pop; unaligned target
        pulse_reset(2);
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            ok = imem_rvalid && InstrValidF && memq.size() >= 1;
            if (ok || k >= 30) break;
            k++;
        end
        check1("t4_sync", ok, 1'b1);
        redirect(32'h0000_0203, 32'h0000_0200);
        wait_pops("t4_pops", 6, 60);
        check("t4_first_addr", glog(0), 32'h0000_0200);

        // Back-to-back redirects: the second target wins
        pulse_reset(3);
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            ok = memq.size() >= 2;
            if (ok || k >= 30) break;
            k++;
        end
        check1("t5_sync", ok, 1'b1);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0300;
        grant_log.delete();
        @(posedge clk);
        #2 PCTargetE = 32'h0000_0400;
        load_exp(32'h0000_0400);
        @(posedge clk);
        #2 PCSrcE = 1'b0;
        wait_pops("t5_pops", 6, 60);
        check("t5_first_addr", glog(0), 32'h0000_0400);

        // Asynchronous reset mid-burst with entries buffered
        @(posedge clk);
        #2 StallD = 1'b1;
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            ok = InstrValidF;
            if (ok || k >= 30) break;
            k++;
        end
        check1("t6_buffered", ok, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check1("t6_valid", InstrValidF, 1'b0);
        check("t6_instr", InstrF, 32'h0000_0013);
        check1("t6_req", imem_req, 1'b0);
        check("t6_pcf", PCF_out, 32'h0);
        StallD = 1'b0;
        load_exp(RST_PC);
        grant_log.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        wait_pops("t6_pops", 6, 40);
        check("t6_first_addr", glog(0), RST_PC);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
